// File: rtl/mipsys_dma_pkg.sv
// Shared definitions for the MM2S DataMover scheduler: command/status field
// positions, the scheduler state encoding and the command word packer.
package mipsys_dma_pkg;

    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_BTT_W     = 23;
    localparam int CMD_INCR_BIT  = 23;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_TAG_LSB   = 64;

    localparam logic CMD_INCR = 1'b1;
    localparam logic CMD_EOF  = 1'b1;

    localparam int STS_OKAY_BIT   = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_STS  = 2'd3
    } state_e;

    function automatic logic [95:0] pack_mm2s_cmd(input logic [22:0] btt,
                                                  input logic [31:0] saddr,
                                                  input logic [3:0]  tag);
        logic [95:0] w;
        w = '0;
        w[CMD_BTT_LSB +: CMD_BTT_W] = btt;
        w[CMD_INCR_BIT]             = CMD_INCR;
        w[CMD_EOF_BIT]              = CMD_EOF;
        w[CMD_SADDR_LSB +: 32]      = saddr;
        w[CMD_TAG_LSB +: 4]         = tag;
        return w;
    endfunction

    // Largest chunk that stays inside the current max_btt-aligned window.
    function automatic logic [31:0] chunk_len(input logic [31:0] addr,
                                              input logic [31:0] rem,
                                              input logic [31:0] max_btt);
        logic [31:0] room;
        room = max_btt - (addr & (max_btt - 32'd1));
        return (rem < room) ? rem : room;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last served
// requester, wrapping; the pointer only moves when a request completes.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic            upd_i,
    input  logic [1:0]      upd_id_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [1:0]      gid_o
);

    logic [1:0] last_q;
    logic       found;

    // First pass covers indices above the pointer, second pass wraps to 0.
    always_comb begin
        gnt_o = '0;
        gid_o = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (2'(i) > last_q)) begin
                gnt_o[i] = 1'b1;
                gid_o    = 2'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                gid_o    = 2'(i);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 2'(NREQ - 1);
        end else if (upd_i) begin
            last_q <= upd_id_i;
        end
    end

endmodule

// File: rtl/mm2s_dma_scheduler.sv
// Serves whole-transfer read requests over one AXI DataMover MM2S channel,
// splitting each into MAX_BTT-aligned commands and steering data to the owner.
module mm2s_dma_scheduler
    import mipsys_dma_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MAX_BTT = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_bytes,
    output logic [95:0]        m_axis_mm2s_cmd_tdata,
    output logic               m_axis_mm2s_cmd_tvalid,
    input  logic               m_axis_mm2s_cmd_tready,
    input  logic [127:0]       s_axis_mm2s_tdata,
    input  logic [15:0]        s_axis_mm2s_tkeep,
    input  logic               s_axis_mm2s_tlast,
    input  logic               s_axis_mm2s_tvalid,
    output logic               s_axis_mm2s_tready,
    input  logic [7:0]         s_axis_mm2s_sts_tdata,
    input  logic               s_axis_mm2s_sts_tvalid,
    output logic               s_axis_mm2s_sts_tready,
    input  logic               s_axis_mm2s_sts_tkeep,
    input  logic               s_axis_mm2s_sts_tlast,
    output logic [127:0]       out_tdata,
    output logic [15:0]        out_tkeep,
    output logic               out_tlast,
    output logic [NREQ-1:0]    out_tvalid,
    input  logic [NREQ-1:0]    out_tready,
    output logic               done,
    output logic [1:0]         done_id,
    output logic               done_err,
    output logic               busy
);

    localparam logic [31:0] BTT_MAX = 32'(MAX_BTT);

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [1:0]      gid_q;
    logic [1:0]      cnt_q;
    logic [31:0]     addr_q;
    logic [31:0]     rem_q;
    logic [31:0]     chunk_q;
    logic            err_q;
    logic [95:0]     cmd_q;
    logic            cmd_valid_q;
    logic            done_q;
    logic [1:0]      done_id_q;
    logic            done_err_q;

    logic [NREQ-1:0] arb_gnt;
    logic [1:0]      arb_gid;
    logic            arb_upd;
    logic [1:0]      arb_upd_id;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_bytes;
    logic [31:0]     first_chunk;
    logic [31:0]     next_addr;
    logic [31:0]     next_rem;
    logic [31:0]     next_chunk;
    logic            req_take;
    logic            sts_hs;
    logic            err_d;
    logic            finish;
    logic            unused_sts_side;

    assign unused_sts_side = s_axis_mm2s_sts_tkeep ^ s_axis_mm2s_sts_tlast;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_i   (req_valid),
        .upd_i   (arb_upd),
        .upd_id_i(arb_upd_id),
        .gnt_o   (arb_gnt),
        .gid_o   (arb_gid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_bytes = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr  = sel_addr  | req_addr[32*i +: 32];
                sel_bytes = sel_bytes | req_bytes[32*i +: 32];
            end
        end
    end

    assign req_take    = (state_q == ST_IDLE) && (|req_valid);
    assign req_ready   = req_take ? arb_gnt : '0;
    assign first_chunk = chunk_len(sel_addr, sel_bytes, BTT_MAX);

    assign next_addr  = addr_q + chunk_q;
    assign next_rem   = rem_q - chunk_q;
    assign next_chunk = chunk_len(next_addr, next_rem, BTT_MAX);

    // Any error bit, a missing OKAY, or a tag that is not the one we issued.
    assign sts_hs = (state_q == ST_STS) && s_axis_mm2s_sts_tvalid;
    assign err_d  = err_q
                  | s_axis_mm2s_sts_tdata[STS_SLVERR_BIT]
                  | s_axis_mm2s_sts_tdata[STS_DECERR_BIT]
                  | s_axis_mm2s_sts_tdata[STS_INTERR_BIT]
                  | ~s_axis_mm2s_sts_tdata[STS_OKAY_BIT]
                  | (s_axis_mm2s_sts_tdata[3:0] != cmd_q[CMD_TAG_LSB +: 4]);
    assign finish = sts_hs && (err_d || (next_rem == 32'd0));

    always_comb begin
        arb_upd    = 1'b0;
        arb_upd_id = gid_q;
        if (req_take && (sel_bytes == 32'd0)) begin
            arb_upd    = 1'b1;
            arb_upd_id = arb_gid;
        end else if (finish) begin
            arb_upd    = 1'b1;
            arb_upd_id = gid_q;
        end
    end

    assign m_axis_mm2s_cmd_tdata  = cmd_q;
    assign m_axis_mm2s_cmd_tvalid = cmd_valid_q;
    assign s_axis_mm2s_sts_tready = (state_q == ST_STS);
    assign s_axis_mm2s_tready     = (state_q == ST_DATA) && (|(out_tready & gnt_q));
    assign out_tvalid             = ((state_q == ST_DATA) && s_axis_mm2s_tvalid) ? gnt_q : '0;
    assign out_tdata              = s_axis_mm2s_tdata;
    assign out_tkeep              = s_axis_mm2s_tkeep;
    assign out_tlast              = (state_q == ST_DATA) && s_axis_mm2s_tlast && (rem_q == chunk_q);
    assign done                   = done_q;
    assign done_id                = done_id_q;
    assign done_err               = done_err_q;
    assign busy                   = (state_q != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gid_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            err_q       <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            done_err_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_take) begin
                        gnt_q  <= arb_gnt;
                        gid_q  <= arb_gid;
                        addr_q <= sel_addr;
                        rem_q  <= sel_bytes;
                        err_q  <= 1'b0;
                        cnt_q  <= '0;
                        if (sel_bytes == 32'd0) begin
                            done_q    <= 1'b1;
                            done_id_q <= arb_gid;
                        end else begin
                            chunk_q     <= first_chunk;
                            cmd_q       <= pack_mm2s_cmd(first_chunk[22:0], sel_addr, {arb_gid, 2'b00});
                            cmd_valid_q <= 1'b1;
                            state_q     <= ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    if (m_axis_mm2s_cmd_tready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (s_axis_mm2s_tvalid && s_axis_mm2s_tready && s_axis_mm2s_tlast) begin
                        state_q <= ST_STS;
                    end
                end
                ST_STS: begin
                    if (sts_hs) begin
                        err_q  <= err_d;
                        addr_q <= next_addr;
                        rem_q  <= next_rem;
                        cnt_q  <= cnt_q + 2'd1;
                        if (finish) begin
                            done_q     <= 1'b1;
                            done_id_q  <= gid_q;
                            done_err_q <= err_d;
                            state_q    <= ST_IDLE;
                        end else begin
                            chunk_q     <= next_chunk;
                            cmd_q       <= pack_mm2s_cmd(next_chunk[22:0], next_addr, {gid_q, cnt_q + 2'd1});
                            cmd_valid_q <= 1'b1;
                            state_q     <= ST_CMD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm2s_dma_scheduler.sv
// Directed bench for mm2s_dma_scheduler: table of transfers plus hand-written
// fairness, reset and latency sequences against a small DataMover model.
module tb_mm2s_dma_scheduler;

    localparam int NREQ = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_bytes;
    logic [95:0]        m_axis_mm2s_cmd_tdata;
    logic               m_axis_mm2s_cmd_tvalid;
    logic               m_axis_mm2s_cmd_tready;
    logic [127:0]       s_axis_mm2s_tdata;
    logic [15:0]        s_axis_mm2s_tkeep;
    logic               s_axis_mm2s_tlast;
    logic               s_axis_mm2s_tvalid;
    logic               s_axis_mm2s_tready;
    logic [7:0]         s_axis_mm2s_sts_tdata;
    logic               s_axis_mm2s_sts_tvalid;
    logic               s_axis_mm2s_sts_tready;
    logic               s_axis_mm2s_sts_tkeep;
    logic               s_axis_mm2s_sts_tlast;
    logic [127:0]       out_tdata;
    logic [15:0]        out_tkeep;
    logic               out_tlast;
    logic [NREQ-1:0]    out_tvalid;
    logic [NREQ-1:0]    out_tready;
    logic               done;
    logic [1:0]         done_id;
    logic               done_err;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [95:0] exp_q[$];

    mm2s_dma_scheduler #(.NREQ(NREQ), .MAX_BTT(4096)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_addr              (req_addr),
        .req_bytes             (req_bytes),
        .m_axis_mm2s_cmd_tdata (m_axis_mm2s_cmd_tdata),
        .m_axis_mm2s_cmd_tvalid(m_axis_mm2s_cmd_tvalid),
        .m_axis_mm2s_cmd_tready(m_axis_mm2s_cmd_tready),
        .s_axis_mm2s_tdata     (s_axis_mm2s_tdata),
        .s_axis_mm2s_tkeep     (s_axis_mm2s_tkeep),
        .s_axis_mm2s_tlast     (s_axis_mm2s_tlast),
        .s_axis_mm2s_tvalid    (s_axis_mm2s_tvalid),
        .s_axis_mm2s_tready    (s_axis_mm2s_tready),
        .s_axis_mm2s_sts_tdata (s_axis_mm2s_sts_tdata),
        .s_axis_mm2s_sts_tvalid(s_axis_mm2s_sts_tvalid),
        .s_axis_mm2s_sts_tready(s_axis_mm2s_sts_tready),
        .s_axis_mm2s_sts_tkeep (s_axis_mm2s_sts_tkeep),
        .s_axis_mm2s_sts_tlast (s_axis_mm2s_sts_tlast),
        .out_tdata             (out_tdata),
        .out_tkeep             (out_tkeep),
        .out_tlast             (out_tlast),
        .out_tvalid            (out_tvalid),
        .out_tready            (out_tready),
        .done                  (done),
        .done_id               (done_id),
        .done_err              (done_err),
        .busy                  (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [95:0] mk_cmd(input logic [31:0] btt, input logic [31:0] a, input logic [3:0] tag);
        return {28'h0, tag, a, 1'b0, 1'b1, 6'h00, 1'b1, btt[22:0]};
    endfunction

    function automatic logic [31:0] chunk_of(input logic [31:0] a, input logic [31:0] r);
        logic [31:0] room;
        room = 32'd4096 - (a & 32'h0000_0FFF);
        return (r < room) ? r : room;
    endfunction

    function automatic logic [127:0] beat_pat(input logic [31:0] a, input int k);
        return {a, ~a, a ^ 32'hA5A5_A5A5, 32'(k)};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_tvalid"}, m_axis_mm2s_cmd_tvalid, 1'b0);
        check({tag, "_cmd_tdata"}, m_axis_mm2s_cmd_tdata, 96'h0);
        check({tag, "_sts_tready"}, s_axis_mm2s_sts_tready, 1'b0);
        check({tag, "_s_tready"}, s_axis_mm2s_tready, 1'b0);
        check({tag, "_out_tvalid"}, out_tvalid, 2'b00);
        check({tag, "_req_ready"}, req_ready, 2'b00);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_done_id"}, done_id, 2'd0);
        check({tag, "_done_err"}, done_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // ---------------- driver tasks ----------------
    // Waits (bounded) for req_ready and checks it grants exactly exp_id.
    task automatic grant_wait(input int exp_id);
        logic [NREQ-1:0] oh;
        int guard;
        oh = '0;
        oh[exp_id] = 1'b1;
        guard = 0;
        #1;
        while (req_ready == '0 && guard < 20) begin
            @(negedge clock);
            #1;
            guard++;
        end
        check("grant", req_ready, oh);
    endtask

    // Called in the grant cycle; acts as requester and DataMover to completion.
    task automatic run_xfer(input int id, input logic [31:0] addr, input logic [31:0] bytes,
                            input int bad_chunk, input logic [7:0] bad_sts, input bit toggle,
                            input bit keep, input bit has_tbl, input logic [95:0] exp_cmd0,
                            output int ncmd, output bit err_seen);
        logic [31:0] a, r, c;
        logic [95:0] exp_cmd;
        logic [3:0]  tag;
        logic [127:0] pat;
        logic [NREQ-1:0] oh;
        int cnt, beats, got, guard;
        bit last_chunk, phase, bad;
        ncmd = 0;
        err_seen = 0;
        oh = '0;
        oh[id] = 1'b1;
        a = addr;
        r = bytes;
        cnt = 0;
        while (r != 0) begin
            c = chunk_of(a, r);
            exp_q.push_back(mk_cmd(c, a, {id[1:0], cnt[1:0]}));
            a = a + c;
            r = r - c;
            cnt++;
        end
        @(negedge clock);
        req_valid[id] = keep;
        out_tready = '1;
        #1;
        if (bytes == 32'd0) begin
            check("zero_done", done, 1'b1);
            check("zero_done_id", done_id, 2'(id));
            check("zero_done_err", done_err, 1'b0);
            check("zero_no_cmd", m_axis_mm2s_cmd_tvalid, 1'b0);
            check("zero_busy", busy, 1'b0);
            return;
        end
        a = addr;
        r = bytes;
        forever begin
            check("cmd_tvalid", m_axis_mm2s_cmd_tvalid, 1'b1);
            exp_cmd = (exp_q.size() > 0) ? exp_q.pop_front() : 96'h0;
            if (has_tbl && ncmd == 0) check("cmd0_table", m_axis_mm2s_cmd_tdata, exp_cmd0);
            check("cmd_tdata", m_axis_mm2s_cmd_tdata, exp_cmd);
            check("cmd_no_data_ready", s_axis_mm2s_tready, 1'b0);
            check("cmd_no_sts_ready", s_axis_mm2s_sts_tready, 1'b0);
            c = chunk_of(a, r);
            tag = exp_cmd[67:64];
            @(negedge clock);
            #1;
            check("cmd_stable", m_axis_mm2s_cmd_tdata, exp_cmd);
            m_axis_mm2s_cmd_tready = 1'b1;
            @(negedge clock);
            m_axis_mm2s_cmd_tready = 1'b0;
            ncmd++;
            last_chunk = (r == c);
            beats = int'(c / 32'd16);
            got = 0;
            guard = 0;
            phase = 1'b0;
            while (got < beats && guard < 4 * beats + 8) begin
                pat = beat_pat(a + 32'(got * 16), got);
                s_axis_mm2s_tvalid = 1'b1;
                s_axis_mm2s_tdata  = pat;
                s_axis_mm2s_tkeep  = got[0] ? 16'h0FFF : 16'hFFFF;
                s_axis_mm2s_tlast  = (got == beats - 1);
                out_tready         = '1;
                out_tready[id]     = toggle ? phase : 1'b1;
                #1;
                check("s_tready", s_axis_mm2s_tready, out_tready[id]);
                check("out_tvalid", out_tvalid, oh);
                check("out_tdata", out_tdata, pat);
                check("out_tkeep", out_tkeep, s_axis_mm2s_tkeep);
                check("out_tlast", out_tlast, (got == beats - 1) && last_chunk);
                if (out_tready[id]) got++;
                phase = ~phase;
                guard++;
                @(negedge clock);
            end
            s_axis_mm2s_tvalid = 1'b0;
            s_axis_mm2s_tlast  = 1'b0;
            out_tready = '1;
            if (got != beats) begin
                check("beat_timeout", 32'(got), 32'(beats));
                return;
            end
            bad = (ncmd - 1 == bad_chunk);
            s_axis_mm2s_sts_tvalid = 1'b1;
            s_axis_mm2s_sts_tdata  = bad ? bad_sts : {4'h8, tag};
            #1;
            check("sts_tready", s_axis_mm2s_sts_tready, 1'b1);
            check("sts_no_data_ready", s_axis_mm2s_tready, 1'b0);
            @(negedge clock);
            s_axis_mm2s_sts_tvalid = 1'b0;
            a = a + c;
            r = r - c;
            #1;
            if (bad || r == 32'd0) begin
                check("done", done, 1'b1);
                check("done_id", done_id, 2'(id));
                err_seen = done_err;
                check("done_no_cmd", m_axis_mm2s_cmd_tvalid, 1'b0);
                check("done_idle", busy, 1'b0);
                exp_q.delete();
                if (bad) begin
                    @(negedge clock);
                    #1;
                    check("err_no_more_cmd", m_axis_mm2s_cmd_tvalid, 1'b0);
                    check("err_done_once", done, 1'b0);
                end
                return;
            end
            check("mid_no_done", done, 1'b0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] bytes;
        int          bad_chunk;
        logic [7:0]  bad_sts;
        bit          toggle;
        logic [95:0] exp_cmd0;
        int          exp_ncmd;
        bit          exp_err;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];

    initial begin
        int ncmd;
        bit err;
        int left[2];
        int exp_id;

        vecs[0] = '{0, 32'h0000_1000, 32'd64,   -1, 8'h00, 1'b0, 96'h0_00001000_40800040, 1, 1'b0};
        vecs[1] = '{1, 32'h0000_0FF0, 32'd48,   -1, 8'h00, 1'b0, 96'h4_00000FF0_40800010, 2, 1'b0};
        vecs[2] = '{0, 32'h0000_2FF0, 32'd4128,  0, 8'h40, 1'b0, 96'h0_00002FF0_40800010, 1, 1'b1};
        vecs[3] = '{1, 32'h0000_3000, 32'd64,   -1, 8'h00, 1'b1, 96'h4_00003000_40800040, 1, 1'b0};
        vecs[4] = '{0, 32'h0000_4000, 32'd0,    -1, 8'h00, 1'b0, 96'h0,                   0, 1'b0};
        vecs[5] = '{1, 32'h0000_5000, 32'd32,    0, 8'h81, 1'b0, 96'h4_00005000_40800020, 1, 1'b1};
        vecs[6] = '{0, 32'hFFFF_FFF0, 32'd32,   -1, 8'h00, 1'b0, 96'h0_FFFFFFF0_40800010, 2, 1'b0};
        vecs[7] = '{1, 32'h0000_6000, 32'd16,    0, 8'h04, 1'b0, 96'h4_00006000_40800010, 1, 1'b1};
        vecs[8] = '{0, 32'h0000_0FF0, 32'd48,    1, 8'hA1, 1'b0, 96'h0_00000FF0_40800010, 2, 1'b1};

        reset = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_bytes = '0;
        m_axis_mm2s_cmd_tready = 1'b0;
        s_axis_mm2s_tdata = '0;
        s_axis_mm2s_tkeep = '0;
        s_axis_mm2s_tlast = 1'b0;
        s_axis_mm2s_tvalid = 1'b0;
        s_axis_mm2s_sts_tdata = '0;
        s_axis_mm2s_sts_tvalid = 1'b0;
        s_axis_mm2s_sts_tkeep = 1'b1;
        s_axis_mm2s_sts_tlast = 1'b1;
        out_tready = '1;
        repeat (3) @(negedge clock);
        #1;
        check_reset_values("rst");
        reset = 1'b0;

        // Fairness: both requesters hold valid for four requests each.
        @(negedge clock);
        req_addr  = {32'h0000_0210, 32'h0000_0100};
        req_bytes = {32'd16, 32'd16};
        req_valid = 2'b11;
        left[0] = 4;
        left[1] = 4;
        for (int k = 0; k < 8; k++) begin
            exp_id = k % 2;
            grant_wait(exp_id);
            left[exp_id]--;
            run_xfer(exp_id, req_addr[32*exp_id +: 32], 32'd16, -1, 8'h00, 1'b0,
                     left[exp_id] > 0, 1'b0, 96'h0, ncmd, err);
            check("fair_ncmd", 32'(ncmd), 32'd1);
        end
        check("fair_all_dropped", req_valid, 2'b00);

        // Table of single-requester transfers.
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clock);
            req_addr[32*vecs[v].id +: 32]  = vecs[v].addr;
            req_bytes[32*vecs[v].id +: 32] = vecs[v].bytes;
            req_valid[vecs[v].id] = 1'b1;
            grant_wait(vecs[v].id);
            run_xfer(vecs[v].id, vecs[v].addr, vecs[v].bytes, vecs[v].bad_chunk, vecs[v].bad_sts,
                     vecs[v].toggle, 1'b0, 1'b1, vecs[v].exp_cmd0, ncmd, err);
            check($sformatf("vec%0d_ncmd", v), 32'(ncmd), 32'(vecs[v].exp_ncmd));
            check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
        end

        // Reset asserted while in DATA.
        @(negedge clock);
        req_addr[31:0]  = 32'h0000_7000;
        req_bytes[31:0] = 32'd64;
        req_valid = 2'b01;
        grant_wait(0);
        @(negedge clock);
        req_valid = 2'b00;
        m_axis_mm2s_cmd_tready = 1'b1;
        @(negedge clock);
        m_axis_mm2s_cmd_tready = 1'b0;
        s_axis_mm2s_tvalid = 1'b1;
        s_axis_mm2s_tdata = beat_pat(32'h0000_7000, 0);
        s_axis_mm2s_tkeep = 16'hFFFF;
        s_axis_mm2s_tlast = 1'b0;
        #1;
        check("rst_mid_in_data", out_tvalid, 2'b01);
        @(negedge clock);
        reset = 1'b1;
        s_axis_mm2s_tvalid = 1'b0;
        @(negedge clock);
        #1;
        check_reset_values("rst_mid");
        reset = 1'b0;

        // After reset requester 0 wins first, then requester 1.
        @(negedge clock);
        req_addr  = {32'h0000_9000, 32'h0000_8000};
        req_bytes = {32'd32, 32'd32};
        req_valid = 2'b11;
        grant_wait(0);
        run_xfer(0, 32'h0000_8000, 32'd32, -1, 8'h00, 1'b0, 1'b0, 1'b1,
                 96'h0_00008000_40800020, ncmd, err);
        check("post_rst0_err", err, 1'b0);
        grant_wait(1);
        run_xfer(1, 32'h0000_9000, 32'd32, -1, 8'h00, 1'b0, 1'b0, 1'b1,
                 96'h4_00009000_40800020, ncmd, err);
        check("post_rst1_err", err, 1'b0);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
